// File: rtl/debug_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// debug_uart_tx_arbiter
//
// Shares one debug UART transmitter between two byte-stream requesters.
// A requester that wins arbitration keeps the UART for its whole frame
// (up to and including the byte flagged *_last). Bytes are handed to the
// UART one at a time: load SBUF, pulse start, wait for the done pulse.
// When both requesters are waiting, a round-robin pointer decides who
// goes next. A stalled requester or a silent UART aborts the frame after
// TIMEOUT_CYCLES. An optional idle gap can follow every completed frame.
//
// Parameters
//   DATA_WIDTH      byte width of requester data and UART SBUF
//   TIMEOUT_CYCLES  max cycles spent stalled in SEND or WAIT before abort
//   GAP_CYCLES      idle cycles inserted after each completed frame
//
// Ports
//   clk                       sole clock, rising edge
//   reset                     asynchronous active-high reset
//   sync_reset                synchronous reset, same effect at next edge
//   req0_/req1_valid/data/last  requester byte streams
//   req0_/req1_ack            one-cycle pop of the presented byte
//   uart_tx_start             one-cycle start pulse to the UART
//   uart_sbuf                 byte presented to the UART
//   uart_tx_done              one-cycle completion pulse from the UART
//   grant                     one-hot owner, 2'b00 when idle
//   busy                      high whenever not IDLE
//   timeout_pulse             one-cycle pulse when a frame is aborted
// -----------------------------------------------------------------------------
module debug_uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int GAP_CYCLES     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sync_reset,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_last,
  output logic                  req0_ack,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_last,
  output logic                  req1_ack,
  output logic                  uart_tx_start,
  output logic [DATA_WIDTH-1:0] uart_sbuf,
  input  logic                  uart_tx_done,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  timeout_pulse
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t                  state_reg;
  logic [1:0]              grant_reg;
  logic                    rr_ptr_reg;
  logic [DATA_WIDTH-1:0]   sbuf_reg;
  logic                    tx_start_reg;
  logic                    last_reg;
  logic                    timeout_pulse_reg;
  logic [TMO_W-1:0]        tmo_cnt_reg;
  logic [GAP_W-1:0]        gap_cnt_reg;

  logic [1:0]              valid_vec;
  logic [1:0]              ack_vec;
  logic                    owner_idx;
  logic                    owner_valid;
  logic                    owner_last;
  logic [DATA_WIDTH-1:0]   owner_data;
  logic                    pick_idx;
  logic                    tmo_terminal;
  logic [TMO_W-1:0]        tmo_cnt_next;

  assign valid_vec = {req1_valid, req0_valid};

  // grant is one-hot, so its upper bit alone identifies the owner
  assign owner_idx   = grant_reg[1];
  assign owner_valid = owner_idx ? req1_valid : req0_valid;
  assign owner_last  = owner_idx ? req1_last  : req0_last;
  assign owner_data  = owner_idx ? req1_data  : req0_data;

  // Lone requester wins outright; a tie goes to the round-robin pointer
  assign pick_idx = (req0_valid && req1_valid) ? rr_ptr_reg : req1_valid;

  assign tmo_terminal = (tmo_cnt_reg == TMO_LAST);
  assign tmo_cnt_next = (tmo_cnt_reg < TMO_LAST) ? tmo_cnt_reg + 1'b1 : tmo_cnt_reg;

  // Ack is combinational so the requester pops in the same cycle the byte
  // is captured into SBUF. A pending synchronous reset suppresses it, since
  // that edge discards the byte instead of loading it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = (state_reg == ST_SEND) && grant_reg[gi] &&
                           valid_vec[gi] && !sync_reset;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      grant_reg         <= 2'b00;
      rr_ptr_reg        <= 1'b0;
      sbuf_reg          <= '0;
      tx_start_reg      <= 1'b0;
      last_reg          <= 1'b0;
      timeout_pulse_reg <= 1'b0;
      tmo_cnt_reg       <= '0;
      gap_cnt_reg       <= '0;
    end else if (sync_reset) begin
      state_reg         <= ST_IDLE;
      grant_reg         <= 2'b00;
      rr_ptr_reg        <= 1'b0;
      sbuf_reg          <= '0;
      tx_start_reg      <= 1'b0;
      last_reg          <= 1'b0;
      timeout_pulse_reg <= 1'b0;
      tmo_cnt_reg       <= '0;
      gap_cnt_reg       <= '0;
    end else begin
      tx_start_reg      <= 1'b0;
      timeout_pulse_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (|valid_vec) begin
            grant_reg   <= pick_idx ? 2'b10 : 2'b01;
            tmo_cnt_reg <= '0;
            state_reg   <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (owner_valid) begin
            sbuf_reg     <= owner_data;
            tx_start_reg <= 1'b1;
            last_reg     <= owner_last;
            tmo_cnt_reg  <= '0;
            state_reg    <= ST_WAIT;
          end else if (tmo_terminal) begin
            // Owner stalled mid-frame: give the UART up
            timeout_pulse_reg <= 1'b1;
            grant_reg         <= 2'b00;
            rr_ptr_reg        <= ~owner_idx;
            tmo_cnt_reg       <= '0;
            state_reg         <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_next;
          end
        end

        ST_WAIT: begin
          // done is tested before the terminal count, so a done arriving on
          // the terminal cycle still completes the byte normally
          if (uart_tx_done) begin
            tmo_cnt_reg <= '0;
            if (last_reg) begin
              grant_reg   <= 2'b00;
              rr_ptr_reg  <= ~owner_idx;
              gap_cnt_reg <= '0;
              state_reg   <= (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end else begin
              state_reg <= ST_SEND;
            end
          end else if (tmo_terminal) begin
            timeout_pulse_reg <= 1'b1;
            grant_reg         <= 2'b00;
            rr_ptr_reg        <= ~owner_idx;
            tmo_cnt_reg       <= '0;
            state_reg         <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_next;
          end
        end

        ST_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            gap_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req0_ack      = ack_vec[0];
  assign req1_ack      = ack_vec[1];
  assign uart_tx_start = tx_start_reg;
  assign uart_sbuf     = sbuf_reg;
  assign grant         = grant_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign timeout_pulse = timeout_pulse_reg;

endmodule

// File: tb/tb_debug_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_debug_uart_tx_arbiter
//
// Directed bench for debug_uart_tx_arbiter (TIMEOUT_CYCLES=16, GAP_CYCLES=4).
// Stimulus pushes requester bytes and the hand-computed sequence of DUT
// events (acks, UART starts, timeouts) into a scoreboard queue; a monitor on
// the falling edge pops and compares each event as the DUT produces it.
// -----------------------------------------------------------------------------
module tb_debug_uart_tx_arbiter;

  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          sync_reset;
  logic          req0_valid, req1_valid;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_last, req1_last;
  logic          req0_ack, req1_ack;
  logic          uart_tx_start;
  logic [DW-1:0] uart_sbuf;
  logic          uart_tx_done;
  logic [1:0]    grant;
  logic          busy;
  logic          timeout_pulse;

  debug_uart_tx_arbiter #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16),
    .GAP_CYCLES     (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sync_reset    (sync_reset),
    .req0_valid    (req0_valid),
    .req0_data     (req0_data),
    .req0_last     (req0_last),
    .req0_ack      (req0_ack),
    .req1_valid    (req1_valid),
    .req1_data     (req1_data),
    .req1_last     (req1_last),
    .req1_ack      (req1_ack),
    .uart_tx_start (uart_tx_start),
    .uart_sbuf     (uart_sbuf),
    .uart_tx_done  (uart_tx_done),
    .grant         (grant),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0]    kind;
    logic [1:0]    gnt;
    logic [DW-1:0] data;
  } ev_t;

  localparam logic [1:0] K_ACK   = 2'd0;
  localparam logic [1:0] K_START = 2'd1;
  localparam logic [1:0] K_TMO   = 2'd2;

  ev_t         sb[$];
  logic [8:0]  rq0[$];
  logic [8:0]  rq1[$];
  bit          pop0, pop1;
  int          checks = 0;
  int          errors = 0;

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_ev(input logic [1:0] k, input logic [1:0] g, input logic [DW-1:0] d);
    ev_t e;
    e.kind = k;
    e.gnt  = g;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_req(input bit r, input logic [DW-1:0] d, input bit l);
    if (r) rq1.push_back({l, d});
    else   rq0.push_back({l, d});
  endtask

  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wait_start actual=no_start required=start_within_100");
    end
  endtask

  // Pulse uart_tx_done n cycles after the start cycle we are currently in
  task automatic finish_done(input int n);
    repeat (n) @(posedge clk);
    #1 uart_tx_done = 1'b1;
    @(posedge clk);
    #1 uart_tx_done = 1'b0;
  endtask

  task automatic serve(input int n);
    wait_start();
    finish_done(n);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=busy required=idle_within_100");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"}, 32'(grant), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_start"}, 32'(uart_tx_start), 32'h0);
    chk({tag, "_sbuf"}, 32'(uart_sbuf), 32'h0);
    chk({tag, "_tmo"}, 32'(timeout_pulse), 32'h0);
    chk({tag, "_acks"}, 32'({req1_ack, req0_ack}), 32'h0);
  endtask

  // --------------------------------------------------- requester byte source
  // Presents the head of each queue; a byte is dropped the edge after its
  // ack was observed.
  initial begin
    logic [8:0] tmp;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (pop0) begin
        pop0 = 1'b0;
        if (rq0.size() > 0) tmp = rq0.pop_front();
      end
      if (pop1) begin
        pop1 = 1'b0;
        if (rq1.size() > 0) tmp = rq1.pop_front();
      end
      req0_valid = (rq0.size() > 0);
      {req0_last, req0_data} = (rq0.size() > 0) ? rq0[0] : 9'h0;
      req1_valid = (rq1.size() > 0);
      {req1_last, req1_data} = (rq1.size() > 0) ? rq1[0] : 9'h0;
    end
  end

  // ------------------------------------------------------------------ monitor
  always @(negedge clk) begin
    int  n;
    ev_t act;
    ev_t req;
    n = int'(req0_ack) + int'(req1_ack) + int'(uart_tx_start) + int'(timeout_pulse);
    if (n > 1) begin
      checks++;
      errors++;
      $display("FAIL multi_event actual=%0d_events required=1", n);
    end else if (n == 1) begin
      if (req0_ack || req1_ack) begin
        act.kind = K_ACK;
        act.gnt  = {req1_ack, req0_ack};
        act.data = req1_ack ? req1_data : req0_data;
        if (req0_ack) pop0 = 1'b1;
        if (req1_ack) pop1 = 1'b1;
      end else if (uart_tx_start) begin
        act.kind = K_START;
        act.gnt  = grant;
        act.data = uart_sbuf;
      end else begin
        act.kind = K_TMO;
        act.gnt  = grant;
        act.data = '0;
      end
      $display("txn t=%0t kind=%0d gnt=%b data=%h", $time, act.kind, act.gnt, act.data);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual kind=%0d gnt=%b data=%h required=none",
                 act.kind, act.gnt, act.data);
      end else begin
        req = sb.pop_front();
        if (act !== req) begin
          errors++;
          $display("FAIL scoreboard actual kind=%0d gnt=%b data=%h required kind=%0d gnt=%b data=%h",
                   act.kind, act.gnt, act.data, req.kind, req.gnt, req.data);
        end
      end
    end
  end

  // ----------------------------------------------------------------- stimulus
  initial begin
    int cnt;
    int lat;
    reset        = 1'b1;
    sync_reset   = 1'b0;
    uart_tx_done = 1'b0;
    pop0         = 1'b0;
    pop1         = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 reset = 1'b0;

    // Two-byte frame from req0, UART done 10 cycles after each start
    @(posedge clk);
    #1;
    push_req(0, 8'h55, 0);
    push_req(0, 8'hAA, 1);
    exp_ev(K_ACK, 2'b01, 8'h55);
    exp_ev(K_START, 2'b01, 8'h55);
    exp_ev(K_ACK, 2'b01, 8'hAA);
    exp_ev(K_START, 2'b01, 8'hAA);
    wait_start();
    chk("frame_grant", 32'(grant), 32'h1);
    finish_done(10);
    serve(10);
    // Four GAP cycles stay busy, then idle with grant released
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    chk("gap_busy_cycles", 32'(cnt), 32'd4);
    chk("frame_end_grant", 32'(grant), 32'h0);

    // Synchronous reset returns rr_ptr to req0, then alternate 0,1,0,1
    @(posedge clk);
    #1 sync_reset = 1'b1;
    @(posedge clk);
    #1 sync_reset = 1'b0;
    push_req(0, 8'h11, 1);
    push_req(1, 8'h22, 1);
    exp_ev(K_ACK, 2'b01, 8'h11);
    exp_ev(K_START, 2'b01, 8'h11);
    exp_ev(K_ACK, 2'b10, 8'h22);
    exp_ev(K_START, 2'b10, 8'h22);
    serve(3);
    serve(3);
    wait_idle();
    push_req(0, 8'h33, 1);
    push_req(1, 8'h44, 1);
    exp_ev(K_ACK, 2'b01, 8'h33);
    exp_ev(K_START, 2'b01, 8'h33);
    exp_ev(K_ACK, 2'b10, 8'h44);
    exp_ev(K_START, 2'b10, 8'h44);
    serve(3);
    serve(3);
    wait_idle();

    // req1 three-byte frame; req0 arrives mid-frame and must wait
    push_req(1, 8'hA1, 0);
    push_req(1, 8'hA2, 0);
    push_req(1, 8'hA3, 1);
    exp_ev(K_ACK, 2'b10, 8'hA1);
    exp_ev(K_START, 2'b10, 8'hA1);
    exp_ev(K_ACK, 2'b10, 8'hA2);
    exp_ev(K_START, 2'b10, 8'hA2);
    exp_ev(K_ACK, 2'b10, 8'hA3);
    exp_ev(K_START, 2'b10, 8'hA3);
    exp_ev(K_ACK, 2'b01, 8'hB1);
    exp_ev(K_START, 2'b01, 8'hB1);
    wait_start();
    push_req(0, 8'hB1, 1);
    finish_done(3);
    serve(3);
    serve(3);
    serve(3);
    wait_idle();

    // Timeout: req1 byte never completes, abort 16 cycles after WAIT entry
    push_req(1, 8'hC3, 1);
    exp_ev(K_ACK, 2'b10, 8'hC3);
    exp_ev(K_START, 2'b10, 8'hC3);
    exp_ev(K_TMO, 2'b00, 8'h00);
    wait_start();
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (timeout_pulse) begin
        lat = i;
        break;
      end
    end
    chk("timeout_latency", 32'(lat), 32'd16);
    chk("timeout_busy", 32'(busy), 32'h0);
    chk("timeout_grant", 32'(grant), 32'h0);
    @(negedge clk);
    chk("timeout_one_cycle", 32'(timeout_pulse), 32'h0);

    // rr_ptr rotated to req0 by the abort; done on the terminal cycle wins
    push_req(0, 8'hD0, 1);
    push_req(1, 8'hD1, 1);
    exp_ev(K_ACK, 2'b01, 8'hD0);
    exp_ev(K_START, 2'b01, 8'hD0);
    exp_ev(K_ACK, 2'b10, 8'hD1);
    exp_ev(K_START, 2'b10, 8'hD1);
    wait_start();
    finish_done(15);
    serve(3);
    wait_idle();

    // Spurious done while idle changes nothing
    @(posedge clk);
    #1 uart_tx_done = 1'b1;
    @(posedge clk);
    #1 uart_tx_done = 1'b0;
    @(negedge clk);
    chk("spurious_done_busy", 32'(busy), 32'h0);
    chk("spurious_done_grant", 32'(grant), 32'h0);

    // Owner stalls in SEND; req1 stays blocked until req0's frame ends
    push_req(0, 8'hE0, 0);
    exp_ev(K_ACK, 2'b01, 8'hE0);
    exp_ev(K_START, 2'b01, 8'hE0);
    exp_ev(K_ACK, 2'b01, 8'hE1);
    exp_ev(K_START, 2'b01, 8'hE1);
    exp_ev(K_ACK, 2'b10, 8'hF0);
    exp_ev(K_START, 2'b10, 8'hF0);
    serve(3);
    repeat (5) @(negedge clk);
    chk("stall_busy", 32'(busy), 32'h1);
    chk("stall_grant", 32'(grant), 32'h1);
    push_req(1, 8'hF0, 1);
    push_req(0, 8'hE1, 1);
    serve(3);
    serve(3);
    wait_idle();

    // Asynchronous reset in WAIT clears outputs at once, frame dropped silently
    push_req(0, 8'h77, 1);
    exp_ev(K_ACK, 2'b01, 8'h77);
    exp_ev(K_START, 2'b01, 8'h77);
    wait_start();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk_reset_outputs("wait_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
